trigger_capture: RTL and testbench

Acquisition stage between the ADC sample stream and the display path. It stores ADC samples in a circular buffer and detects a level crossing with a configurable slope and hysteresis. When a trigger occurs it freezes one 640-sample frame aligned so the trigger sits at a fixed pre-trigger offset. The pixel pipeline then reads the frozen frame by screen column, which gives a stable trace in place of the free-running shift register.

---
 rtl/scope_pkg.sv | 20 ++
 rtl/capture_ram.sv | 42 ++++
 rtl/trigger_capture.sv | 218 +++++++++++++++++++++
 tb/tb_trigger_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared definitions for the acquisition path: capture FSM states, trigger
// mode encodings and default frame geometry.
package scope_pkg;

  localparam int DEPTH_DEF  = 640;
  localparam int DATA_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_FILL = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POST     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: synchronous write port, registered read port.
// The read register is reset so the display sees 0 straight out of reset; the
// array itself is never cleared.
module capture_ram
  import scope_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Store one sample per write strobe.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Array lookup for the read register.
  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Registered read data, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trigger_capture.sv
// Trigger/capture stage: writes ADC samples into a circular buffer, detects a
// hysteresis-qualified level crossing and freezes one frame around it so that
// the trigger sample lands at frame index PRETRIG. The display reads the frozen
// frame by column through a start-pointer translation.
//
// Handshake: i_sample_valid is a one-cycle strobe with no back-pressure; a
// sample is consumed on the rising edge where the strobe is high, provided the
// FSM is in PRE_FILL, ARMED or POST. Samples arriving in IDLE or DONE are dropped.
module trigger_capture
  import scope_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int PRETRIG      = 320,
  parameter int HYST         = 8,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_level,
  input  logic              i_slope,
  input  logic [1:0]        i_mode,
  input  logic              i_arm,
  input  logic              i_rearm,
  input  logic [9:0]        i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [2:0]        o_state,
  output logic              o_triggered,
  output logic              o_frame_done
);

  localparam int AW     = $clog2(DEPTH);
  localparam int MAXCNT = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
  localparam int CW     = $clog2(MAXCNT + 1);
  localparam int POST_N = DEPTH - PRETRIG - 1;

  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [10:0]     DEPTH_R   = 11'(DEPTH);
  localparam logic [AW:0]     DEPTH_X   = (AW+1)'(DEPTH);
  localparam logic [AW:0]     BACK_X    = (AW+1)'(DEPTH - PRETRIG);
  localparam logic [CW-1:0]   PRE_LAST  = CW'(PRETRIG - 1);
  localparam logic [CW-1:0]   POST_LAST = CW'(POST_N - 1);
  localparam logic [CW-1:0]   AUTO_T    = CW'(AUTO_TIMEOUT);
  localparam logic [DATA_W:0] HYST_X    = (DATA_W+1)'(HYST);
  localparam logic [DATA_W:0] MAXV_X    = {1'b0, {DATA_W{1'b1}}};

  state_e            state_q,     state_d;
  logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic              qual_q,      qual_d;
  logic [AW-1:0]     trig_ptr_q,  trig_ptr_d;
  logic [AW-1:0]     start_ptr_q, start_ptr_d;
  logic              triggered_q, triggered_d;
  logic              frame_done_q, frame_done_d;
  logic              rd_oob_q,    rd_oob_d;

  logic              we;
  logic              is_single, is_auto;
  logic [DATA_W:0]   lvl_x, smp_x, lo_x, hi_x;
  logic              qual_set, level_hit, qual_now;
  logic [AW-1:0]     ram_rd_addr;
  logic [AW:0]       rd_sum;
  logic [DATA_W-1:0] ram_rd_data;

  // Frame start for a given trigger address: (tp - PRETRIG) mod DEPTH.
  function automatic logic [AW-1:0] frame_start(input logic [AW-1:0] tp);
    logic [AW:0] s;
    s = {1'b0, tp} + BACK_X;
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[AW-1:0];
  endfunction

  assign is_single = (i_mode == MODE_SINGLE);
  assign is_auto   = (i_mode == MODE_AUTO);

  // Saturating hysteresis thresholds and per-sample qualifier/crossing tests.
  always_comb begin
    lvl_x = {1'b0, i_level};
    smp_x = {1'b0, i_sample};
    lo_x  = (lvl_x >= HYST_X) ? (lvl_x - HYST_X) : '0;
    hi_x  = lvl_x + HYST_X;
    if (hi_x > MAXV_X) hi_x = MAXV_X;
    qual_set  = i_slope ? (smp_x >= hi_x) : (smp_x <= lo_x);
    level_hit = i_slope ? (i_sample <= i_level) : (i_sample >= i_level);
    qual_now  = qual_q | qual_set;
  end

  // Capture FSM next-state, pointers, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    qual_d       = qual_q;
    trig_ptr_d   = trig_ptr_q;
    start_ptr_d  = start_ptr_q;
    triggered_d  = triggered_q;
    frame_done_d = 1'b0;
    we           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!is_single || i_arm) begin
          state_d = ST_PRE_FILL;
          cnt_d   = '0;
        end
      end
      ST_PRE_FILL: begin
        if (PRETRIG == 0) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
          qual_d  = 1'b0;
        end else if (i_sample_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PRE_LAST) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
            qual_d  = 1'b0;
          end
        end
      end
      ST_ARMED: begin
        if (i_sample_valid) begin
          we     = 1'b1;
          qual_d = qual_now;
          if ((qual_now && level_hit) || (is_auto && cnt_q >= AUTO_T)) begin
            trig_ptr_d  = wr_ptr_q;
            triggered_d = qual_now && level_hit;
            cnt_d       = '0;
            if (POST_N == 0) begin
              state_d      = ST_DONE;
              start_ptr_d  = frame_start(wr_ptr_q);
              frame_done_d = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end else if (cnt_q < AUTO_T) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_POST: begin
        if (i_sample_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == POST_LAST) begin
            state_d      = ST_DONE;
            start_ptr_d  = frame_start(trig_ptr_q);
            frame_done_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if ((is_single && i_arm) || (!is_single && i_rearm)) begin
          state_d = ST_PRE_FILL;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (we) wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
  end

  // Screen column to buffer address; out-of-range columns read as 0.
  always_comb begin
    rd_sum   = {1'b0, start_ptr_q} + (AW+1)'(i_rd_addr);
    rd_oob_d = (i_rd_addr >= DEPTH_R[9:0]) || (DEPTH_R > 11'd1023 && 1'b0);
    if (rd_oob_d)               ram_rd_addr = '0;
    else if (rd_sum >= DEPTH_X) ram_rd_addr = AW'(rd_sum - DEPTH_X);
    else                        ram_rd_addr = rd_sum[AW-1:0];
  end

  // All capture state, asynchronously cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      qual_q       <= 1'b0;
      trig_ptr_q   <= '0;
      start_ptr_q  <= '0;
      triggered_q  <= 1'b0;
      frame_done_q <= 1'b0;
      rd_oob_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      qual_q       <= qual_d;
      trig_ptr_q   <= trig_ptr_d;
      start_ptr_q  <= start_ptr_d;
      triggered_q  <= triggered_d;
      frame_done_q <= frame_done_d;
      rd_oob_q     <= rd_oob_d;
    end
  end

  capture_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .we      (we),
    .wr_addr (wr_ptr_q),
    .wr_data (i_sample),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  assign o_rd_data    = rd_oob_q ? '0 : ram_rd_data;
  assign o_state      = state_q;
  assign o_triggered  = triggered_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture: streams of samples are built per scenario, a
// sequence-level model finds the trigger sample and the frame that must be
// frozen around it, and every read column is checked against that frame.
module tb_trigger_capture;
  import scope_pkg::*;

  localparam int DEPTH        = 640;
  localparam int DATA_W       = 10;
  localparam int PRETRIG      = 320;
  localparam int HYST         = 8;
  localparam int AUTO_TIMEOUT = 1024;
  localparam int MAXV         = 1023;
  localparam int POST_N       = DEPTH - PRETRIG - 1;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_sample_valid;
  logic [DATA_W-1:0] i_sample;
  logic [DATA_W-1:0] i_level;
  logic              i_slope;
  logic [1:0]        i_mode;
  logic              i_arm;
  logic              i_rearm;
  logic [9:0]        i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic [2:0]        o_state;
  logic              o_triggered;
  logic              o_frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int stream_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int last_t;

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  trigger_capture #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .PRETRIG(PRETRIG),
    .HYST(HYST), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample_valid(i_sample_valid),
    .i_sample(i_sample), .i_level(i_level), .i_slope(i_slope),
    .i_mode(i_mode), .i_arm(i_arm), .i_rearm(i_rearm),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_state(o_state),
    .o_triggered(o_triggered), .o_frame_done(o_frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic send_sample(input int v, output bit fd, output int st);
    @(negedge i_clk);
    i_sample_valid = 1'b1;
    i_sample       = DATA_W'(v);
    @(posedge i_clk);
    #1;
    fd = o_frame_done;
    st = int'(o_state);
    @(negedge i_clk);
    i_sample_valid = 1'b0;
  endtask

  task automatic pulse_rearm();
    @(negedge i_clk); i_rearm = 1'b1;
    @(negedge i_clk); i_rearm = 1'b0;
  endtask

  task automatic pulse_arm();
    @(negedge i_clk); i_arm = 1'b1;
    @(negedge i_clk); i_arm = 1'b0;
  endtask

  task automatic rd_one(input int a, output int d);
    @(negedge i_clk); i_rd_addr = 10'(a);
    @(negedge i_clk); d = int'(o_rd_data);
  endtask

  task automatic push_n(input int v, input int n);
    for (int i = 0; i < n; i++) stream_q.push_back(v);
  endtask

  task automatic push_rand(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) stream_q.push_back(int'($urandom_range(hi, lo)));
  endtask

  // Reference: scan the sample sequence of one capture with the trigger rules.
  function automatic void model(input int mode, input int slope, input int level,
                                output int t, output bit real_trig);
    int lo, hi, s;
    bit qual;
    t = -1; real_trig = 1'b0; qual = 1'b0;
    lo = (level - HYST < 0) ? 0 : level - HYST;
    hi = (level + HYST > MAXV) ? MAXV : level + HYST;
    for (int k = PRETRIG; k < stream_q.size(); k++) begin
      s = stream_q[k];
      if (slope == 0 ? (s <= lo) : (s >= hi)) qual = 1'b1;
      if (qual && (slope == 0 ? (s >= level) : (s <= level))) begin
        t = k; real_trig = 1'b1; return;
      end
      if (mode == 0 && (k - PRETRIG) >= AUTO_TIMEOUT) begin
        t = k; return;
      end
    end
  endfunction

  // scoreboard: frame must be stream[t-PRETRIG .. t+POST_N]
  task automatic read_frame(input string tag, input int t);
    int d;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(DATA_W'(stream_q[t - PRETRIG + i]));
    for (int i = 0; i < DEPTH; i++) begin
      rd_one(i, d);
      check_eq($sformatf("%s_rd%0d", tag, i), d, exp_q.pop_front());
    end
    rd_one(DEPTH, d);
    check_eq({tag, "_rd_oob640"}, d, 0);
    rd_one(1023, d);
    check_eq({tag, "_rd_oob1023"}, d, 0);
  endtask

  task automatic run_capture(input string tag, input int mode, input int slope, input int level);
    int t, done_idx, st, fd_cnt;
    bit real_trig, fd, fd_last;
    i_mode = 2'(mode); i_slope = slope[0]; i_level = DATA_W'(level);
    model(mode, slope, level, t, real_trig);
    if (t < 0) begin
      n_errors++;
      $display("FAIL %s stimulus holds no trigger", tag);
      return;
    end
    done_idx = t + POST_N;
    while (stream_q.size() <= done_idx) stream_q.push_back(int'($urandom_range(MAXV, 0)));
    check_eq({tag, "_prefill_state"}, o_state, ST_PRE_FILL);
    fd_cnt = 0; fd_last = 1'b0;
    for (int k = 0; k <= done_idx; k++) begin
      send_sample(stream_q[k], fd, st);
      if (fd) fd_cnt++;
      if (k == done_idx) fd_last = fd;
      if (k == t) check_eq({tag, "_post_entry"}, st, ST_POST);
    end
    check_eq({tag, "_done_pulses"}, fd_cnt, 1);
    check_eq({tag, "_done_on_last"}, fd_last, 1);
    check_eq({tag, "_done_state"}, o_state, ST_DONE);
    check_eq({tag, "_triggered"}, o_triggered, real_trig);
    @(posedge i_clk); #1;
    check_eq({tag, "_done_one_cycle"}, o_frame_done, 0);
    read_frame(tag, t);
    last_t = t;
  endtask

  initial begin
    int d, t, st, lvl, slope;
    bit real_trig, fd;
    i_rst_n = 1'b0; i_sample_valid = 1'b0; i_sample = '0; i_level = '0;
    i_slope = 1'b0; i_mode = MODE_NORMAL; i_arm = 1'b0; i_rearm = 1'b0;
    i_rd_addr = '0;
    #12;
    check_eq("rst_state", o_state, ST_IDLE);
    check_eq("rst_rd_data", o_rd_data, 0);
    check_eq("rst_triggered", o_triggered, 0);
    check_eq("rst_frame_done", o_frame_done, 0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(negedge i_clk);

    // 1: ramp, rising, level 512
    stream_q.delete();
    for (int i = 0; i < 1024; i++) stream_q.push_back(i);
    run_capture("ramp", 1, 0, 512);
    rd_one(0, d);   check_eq("ramp_col0", d, 192);
    rd_one(320, d); check_eq("ramp_col320", d, 512);
    rd_one(639, d); check_eq("ramp_col639", d, 831);
    pulse_rearm();

    // 2: hysteresis blocks the near-level bounce
    stream_q.delete();
    push_n(700, 600);
    stream_q.push_back(505); stream_q.push_back(515);
    stream_q.push_back(400); stream_q.push_back(520);
    run_capture("hyst", 1, 0, 512);
    rd_one(320, d); check_eq("hyst_col320", d, 520);
    pulse_rearm();

    // 4: falling slope, level 100, then level 5 with clamped thresholds
    stream_q.delete();
    push_n(50, PRETRIG);
    stream_q.push_back(300); stream_q.push_back(200); stream_q.push_back(99);
    run_capture("fall", 1, 1, 100);
    rd_one(319, d); check_eq("fall_col319", d, 200);
    pulse_rearm();
    stream_q.delete();
    push_n(0, PRETRIG);
    stream_q.push_back(12); stream_q.push_back(3);
    stream_q.push_back(13); stream_q.push_back(4);
    run_capture("fall_low", 1, 1, 5);
    rd_one(320, d); check_eq("fall_low_col320", d, 4);

    // 3: auto mode forced trigger on a constant input
    i_mode = MODE_AUTO;
    pulse_rearm();
    stream_q.delete();
    push_n(300, PRETRIG + AUTO_TIMEOUT + 1);
    run_capture("auto", 0, 0, 512);

    // randomized captures in auto mode, some unable to qualify
    for (int r = 0; r < 4; r++) begin
      pulse_rearm();
      lvl = int'($urandom_range(1000, 20));
      slope = int'($urandom_range(1, 0));
      stream_q.delete();
      if (r % 2 == 0) push_rand(PRETRIG + 1100, 0, MAXV);
      else if (slope == 0) push_rand(PRETRIG + 1100, lvl - HYST + 1, MAXV);
      else push_rand(PRETRIG + 1100, 0, lvl + HYST - 1);
      run_capture($sformatf("rand%0d", r), 0, slope, lvl);
    end

    // 5: single mode
    i_mode = MODE_SINGLE;
    #3 i_rst_n = 1'b0;
    @(negedge i_clk); i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);
    check_eq("single_idle_hold", o_state, ST_IDLE);
    pulse_arm();
    stream_q.delete();
    push_rand(PRETRIG + 300, 0, MAXV);
    stream_q.push_back(0); stream_q.push_back(MAXV);
    lvl = int'($urandom_range(900, 100));
    run_capture("single", 2, 0, lvl);
    pulse_rearm();
    pulse_rearm();
    check_eq("single_rearm_ignored", o_state, ST_DONE);
    read_frame("single_hold", last_t);
    @(negedge i_clk);
    i_arm = 1'b1; i_sample_valid = 1'b1; i_sample = 10'd777;
    @(negedge i_clk);
    i_arm = 1'b0; i_sample_valid = 1'b0;
    @(negedge i_clk);
    stream_q.delete();
    push_rand(PRETRIG + 300, 0, MAXV);
    stream_q.push_back(MAXV); stream_q.push_back(0);
    run_capture("single_drop", 2, 1, lvl);

    // 6: asynchronous reset in POST, then recapture
    i_mode = MODE_NORMAL;
    pulse_rearm();
    stream_q.delete();
    push_rand(PRETRIG + 200, 0, MAXV);
    stream_q.push_back(0); stream_q.push_back(MAXV);
    model(1, 0, 512, t, real_trig);
    i_slope = 1'b0; i_level = 10'd512;
    if (t < 0) begin
      n_errors++;
      $display("FAIL midrst stimulus holds no trigger");
    end else begin
      for (int k = 0; k <= t + 10; k++) send_sample(stream_q[k], fd, st);
      check_eq("midrst_in_post", st, ST_POST);
    end
    #2 i_rst_n = 1'b0;
    #1;
    check_eq("midrst_state", o_state, ST_IDLE);
    check_eq("midrst_rd_data", o_rd_data, 0);
    check_eq("midrst_frame_done", o_frame_done, 0);
    check_eq("midrst_triggered", o_triggered, 0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(negedge i_clk);
    stream_q.delete();
    push_rand(PRETRIG + 200, 0, MAXV);
    stream_q.push_back(0); stream_q.push_back(MAXV);
    run_capture("recap", 1, 0, 512);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
